// File: rtl/nv_ram_rws_32x272_fifo_ctrl_if.sv
// Push/pop valid-ready bundle for the 32x272 RAM FIFO controller.
// Master drives push data and pop ready; slave is the controller.
interface nv_ram_rws_32x272_fifo_ctrl_if #(
  parameter int DW = 272
) ();
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;

  modport master (
    output wr_pvld, wr_pd, rd_prdy,
    input  wr_prdy, rd_pvld, rd_pd
  );

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy,
    output wr_prdy, rd_pvld, rd_pd
  );
endinterface

// File: rtl/nv_ram_rws_32x272_fifo_ctrl.sv
// Pointer and flow control around an external 32x272 RAM with
// registered read address; pop data comes straight from the RAM.
module nv_ram_rws_32x272_fifo_ctrl #(
  parameter int DW = 272,
  parameter int AW = 5
) (
  input  logic           nvdla_core_clk,
  input  logic           nvdla_core_rstn,
  nv_ram_rws_32x272_fifo_ctrl_if.slave io,
  output logic           ram_we,
  output logic [AW-1:0]  ram_wa,
  output logic [DW-1:0]  ram_di,
  output logic           ram_re,
  output logic [AW-1:0]  ram_ra,
  input  logic [DW-1:0]  ram_dout,
  input  logic [31:0]    pwrbus_ram_pd,
  output logic [31:0]    ram_pwrbus_ram_pd,
  output logic [AW:0]    fifo_occ,
  output logic           fifo_idle
);
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [AW:0]   unread_q, unread_d;
  logic          ram_vld_q, ram_vld_d;
  logic          push, pop, issue;

  assign io.wr_prdy = (occ_q != FULL);
  assign push  = io.wr_pvld & io.wr_prdy;
  // Slots free only on pop, so the entry on ram_dout is never overwritten.
  assign issue = (unread_q != '0) & (~ram_vld_q | io.rd_prdy);
  assign pop   = ram_vld_q & io.rd_prdy;

  assign ram_we = push;
  assign ram_wa = wr_ptr_q;
  assign ram_di = io.wr_pd;
  assign ram_re = issue;
  assign ram_ra = rd_ptr_q;

  assign io.rd_pvld = ram_vld_q;
  assign io.rd_pd   = ram_dout;

  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;
  assign fifo_occ  = occ_q;
  assign fifo_idle = (occ_q == '0);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    unread_d  = unread_q;
    ram_vld_d = ram_vld_q;
    if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
    occ_d = occ_q + {{AW{1'b0}}, push}
          - {{AW{1'b0}}, pop};
    unread_d = unread_q + {{AW{1'b0}}, push}
             - {{AW{1'b0}}, issue};
    if (issue)
      ram_vld_d = 1'b1;
    else if (io.rd_prdy)
      ram_vld_d = 1'b0;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      unread_q  <= '0;
      ram_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      unread_q  <= unread_d;
      ram_vld_q <= ram_vld_d;
    end
  end

  a_occ_max: assert property (@(posedge nvdla_core_clk)
    disable iff (!nvdla_core_rstn) occ_q <= FULL);
  a_unread_le_occ: assert property (@(posedge nvdla_core_clk)
    disable iff (!nvdla_core_rstn) unread_q <= occ_q);
  a_vld_gap: assert property (@(posedge nvdla_core_clk)
    disable iff (!nvdla_core_rstn)
    (occ_q - unread_q) == {{AW{1'b0}}, ram_vld_q});
  a_ptr_gap: assert property (@(posedge nvdla_core_clk)
    disable iff (!nvdla_core_rstn)
    (wr_ptr_q - rd_ptr_q) == unread_q[AW-1:0]);
  a_no_ovf: assert property (@(posedge nvdla_core_clk)
    disable iff (!nvdla_core_rstn) ram_we |-> io.wr_prdy);
endmodule

// File: doc/nv_ram_rws_32x272_fifo_ctrl.md
Name: nv_ram_rws_32x272_fifo_ctrl

Overview:
FIFO controller that owns the pointers and flow control around one external 32x272 two-port RAM with registered read address. The RAM latches its read address on a clock edge when re=1, and its data output reflects that address from then on.
Upstream side is a valid/ready push interface; downstream side is a valid/ready pop interface presented directly from the RAM read port.
Sits between a producer pipe stage and a consumer in the core clock domain. Gives in-order, full-throughput (1 beat/clk) buffering with no output register.

Parameters:
DW, 272, data width; must match RAM width
AW, 5, RAM address width; DEPTH = 2**AW = 32 (derived, not overridable)

Ports:
nvdla_core_clk  input  1  core clock
nvdla_core_rstn  input  1  asynchronous active-low reset
wr_pvld  input  1  push valid
wr_prdy  output  1  push ready
wr_pd  input  DW  push data
rd_pvld  output  1  pop valid
rd_prdy  input  1  pop ready
rd_pd  output  DW  pop data
ram_we  output  1  RAM write enable
ram_wa  output  AW  RAM write address
ram_di  output  DW  RAM write data
ram_re  output  1  RAM read enable
ram_ra  output  AW  RAM read address
ram_dout  input  DW  RAM read data (valid the cycle after ram_re)
pwrbus_ram_pd  input  32  RAM power control; passed through
ram_pwrbus_ram_pd  output  32  to RAM, equal to pwrbus_ram_pd
fifo_occ  output  AW+1  entries held, 0..32
fifo_idle  output  1  fifo_occ==0

Behaviour:
- State: wr_ptr[AW-1:0], rd_ptr[AW-1:0], occ[AW:0] (entries written, not yet popped), unread[AW:0] (entries written, not yet issued to RAM read), ram_vld (RAM output holds an unpopped entry). All reset to 0 asynchronously on nvdla_core_rstn low. RAM contents are not reset.
- Reset output values: wr_prdy=1, rd_pvld=0, ram_we=0, ram_re=0, fifo_occ=0, fifo_idle=1.
- Push: wr_prdy = (occ != DEPTH), combinational from registered occ. push = wr_pvld & wr_prdy.
  - ram_we=push, ram_wa=wr_ptr, ram_di=wr_pd, all combinational.
  - wr_ptr increments on push and wraps 31->0 naturally.
- Read issue: issue = (unread != 0) & (!ram_vld | rd_prdy).
  - ram_re=issue, ram_ra=rd_ptr. rd_ptr increments on issue and wraps 31->0.
- ram_vld next value = issue ? 1 : (rd_prdy ? 0 : ram_vld).
- Pop: rd_pvld=ram_vld, rd_pd=ram_dout. pop = rd_pvld & rd_prdy.
- Counter update: occ += push - pop; unread += push - issue. Simultaneous events net out in the same cycle.
- Slot reuse: a slot is freed only on pop, never on issue. The entry presented on ram_dout therefore cannot be overwritten. rd_pd is stable while rd_pvld & !rd_prdy.
- Same-cycle write/read of one address cannot occur: issue requires unread>0, so the slot being read was written in an earlier cycle.
- Latency: push accepted at edge N gives ram_re in cycle N+1 (if idle) and rd_pvld in cycle N+2. Steady-state throughput is 1 beat/clk with rd_prdy=1.
- Full: occ==32 gives wr_prdy=0, even if pop occurs that cycle (no same-cycle bypass). wr_prdy returns to 1 in the cycle after a pop.
- Empty: unread==0 gives no ram_re. rd_pvld drops the cycle after the last pop.
- Invariants (assert in sim): occ<=32; unread<=occ; occ-unread == ram_vld; wr_ptr-rd_ptr == unread mod 32; push while !wr_prdy never occurs.
- Reset mid-operation: all state clears immediately. In-flight data is discarded, and the first push after release is the first data popped.

Test Plan:
1. Reset, no stimulus -> wr_prdy=1, rd_pvld=0, ram_we=0, ram_re=0, fifo_occ=0, fifo_idle=1.
2. Single push wr_pd=0xA5 at cycle 0, rd_prdy=1 -> ram_we=1/ram_wa=0 in cycle 0; ram_re=1/ram_ra=0 in cycle 1; rd_pvld=1 with rd_pd=0xA5 in cycle 2; fifo_occ=0 in cycle 3.
3. rd_prdy=0, 33 pushes of values 0..32 ->
   - first 32 accepted; wr_prdy=0 after the 32nd and value 32 is held;
   - ram_re pulses exactly once (ra=0); rd_pd=0 stays stable; fifo_occ=32.
   - Then one pop -> wr_prdy=1 the next cycle and value 32 is written to addr 0.
4. Continuous push of 100 incrementing beats with rd_prdy=1 -> 100 beats out in order, one per cycle after 2-cycle latency; both pointers wrap 31->0 three times; fifo_occ never exceeds 2.
5. Random wr_pvld/rd_prdy (50%), 2000 beats -> output order matches input; rd_pd constant while stalled; all invariants hold.
6. nvdla_core_rstn asserted asynchronously with fifo_occ=10 -> outputs reach reset values without a clock edge. After release, push 0x1234 -> next rd_pd is 0x1234, not stale data.
